pwm_multi: RTL
==============

# pwm_multi

Parametrised multi-channel PWM generator for the miniCar motor/servo drive path: one shared period counter with prescaler drives CHANNELS independent comparators. Adds edge- or center-aligned counting, per-channel output inversion, and glitch-free double-buffered duty and period updates committed only at period boundaries. Sits between the control/speed logic, which writes duties, and the motor driver pins.

## Interface
- CHANNELS, 4, number of PWM outputs
- CNT_W, 8, width of counter, period and duty values
- PRE_W, 8, width of prescaler value
- PERIOD_RST, 99, active period top value after reset
- clk_in  input  1  system clock; one clock, all logic on rising edge
- rst  input  1  reset is synchronous and active-high
- enable  input  1  run counter; low = hold idle
- center_mode  input  1  0 edge-aligned, 1 center-aligned; staged, committed at period start
- period  input  CNT_W  counter top value P; staged, committed at period start
- prescale  input  PRE_W  counter advances every prescale+1 clocks; staged, committed at period start
- duty_in  input  CHANNELS*CNT_W  packed duties, channel i at bits [i*CNT_W +: CNT_W]
- duty_wr  input  1  one-cycle strobe: latch duty_in into shadow
- invert  input  CHANNELS  per-channel output polarity, applied combinationally before output register
- pwm_out  output  CHANNELS  registered PWM outputs
- duty_busy  output  1  shadow holds an uncommitted write
- period_start  output  1  one-cycle pulse when counter becomes 0 and staged values commit
- cnt_out  output  CNT_W  current counter value

## Operation
- Prescaler: pre_cnt counts 0..prescale_act; tick = (pre_cnt == prescale_act) && enable; pre_cnt wraps to 0 on tick.
- Edge mode: on tick, cnt goes 0,1,...,P, then 0. Period = (P+1) ticks.
- Center mode: on tick, cnt goes 0 up to P, then P-1 down to 0, then up again. Direction flag is internal. Period = 2P ticks. P=0 behaves as edge mode.
- Compare, per channel: raw_i = (cnt < duty_act_i). duty=0 gives constant low. duty > P gives constant high. pwm_out_i <= raw_i XOR invert_i.
- Commit event: the tick on which cnt becomes 0 (from P in edge mode, from 1 in center mode). On commit:
  - duty_act <= shadow if busy
  - period_act, prescale_act and mode_act <= the current inputs
  - period_start = 1 for that cycle
  - busy <= 0
- duty_wr: shadow <= duty_in; busy <= 1. A write while busy overwrites the shadow (last write wins). A write in the same cycle as a commit lands in shadow and stays pending; busy stays 1 and the commit uses the old shadow.
- enable=0:
  - cnt, pre_cnt and direction are held at 0/up.
  - Every cycle is a commit without a period_start pulse: pending shadow and staged inputs commit and busy clears next cycle.
  - pwm_out is compared against cnt=0, so each channel outputs active level iff its duty_act ≥ 1.
- Reset values: cnt=0, pre_cnt=0, direction up, duty_act=0, shadow=0, busy=0, period_act=PERIOD_RST, prescale_act=0, mode_act=edge, pwm_out=0, period_start=0.
- Reset mid-period overrides everything. A pending write is discarded.
- period lowered below the current cnt: no effect until commit, because period_act is used.

## Timing
- pwm_out lags cnt by one clock; cnt_out and period_start are aligned with the cnt register.
- duty_wr at cycle t gives busy=1 at t+1. The new duty is visible on pwm_out one clock after the next period_start.
- Worst-case write-to-effect latency is one full period plus 1 clock.
- period_start is exactly 1 clock wide, once per period. The first pulse after enable rises comes at the first wrap.
- The compare path uses registered values only. No combinational path from inputs to outputs.

## Test plan
- Reset, enable=1, prescale=0, period=99, duty ch0=25: ch0 high for 25 clocks and low for 75, repeating every 100. period_start every 100 clocks. Other channels constant 0.
- Boundary duties, P=9: duty 0 gives constant low, duty 10 and 255 give constant high, duty 5 gives 5 high / 5 low. invert=1 on duty 0 gives constant high.
- Center mode, P=4, duty 2, prescale=0: cnt sequence 0,1,2,3,4,3,2,1 repeating. Output high while cnt<2, i.e. 3 clocks per 8-clock period, centered on cnt=0.
- Prescale=3, P=9, duty 3: period 40 clocks, high 12 clocks; cnt_out changes every 4th clock.
- Double buffer:
  - duty_wr 20, then 70 mid-period: busy=1 until the next period_start.
  - Only 70 takes effect; 20 never appears on pwm_out.
  - A write coinciding with period_start stays pending and commits one period later.
- Disable/reset mid-period: enable=0 at cnt=50 sets cnt to 0 next clock with no period_start; a pending duty commits and busy drops within 1 clock. rst at cnt=50 returns every output to its reset value next clock.

Source files
------------

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled period counter, per-channel compare,
// double-buffered duty and staged period/prescale/mode committed at period start.
module pwm_multi #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 8,
  parameter int PRE_W      = 8,
  parameter int PERIOD_RST = 99
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      center_mode,
  input  logic [CNT_W-1:0]          period,
  input  logic [PRE_W-1:0]          prescale,
  input  logic [CHANNELS*CNT_W-1:0] duty_in,
  input  logic                      duty_wr,
  input  logic [CHANNELS-1:0]       invert,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      duty_busy,
  output logic                      period_start,
  output logic [CNT_W-1:0]          cnt_out
);

  logic [PRE_W-1:0]          pre_cnt;
  logic [PRE_W-1:0]          prescale_act;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_nxt;
  logic [CNT_W-1:0]          period_act;
  logic                      dir_down;
  logic                      dir_nxt;
  logic                      mode_act;
  logic [CHANNELS*CNT_W-1:0] shadow;
  logic [CHANNELS*CNT_W-1:0] duty_act;
  logic                      busy;
  logic                      tick;
  logic                      wrap;
  logic                      commit;
  logic                      edge_eff;
  logic [CHANNELS-1:0]       raw;

  assign tick     = enable && (pre_cnt == prescale_act);
  assign edge_eff = !mode_act || (period_act == '0);
  assign commit   = wrap || !enable;

  // wrap marks the tick on which cnt returns to 0
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir_down;
    wrap    = 1'b0;
    if (tick) begin
      unique case (1'b1)
        edge_eff: begin
          if (cnt >= period_act) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
            wrap    = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        dir_down: begin
          if (cnt <= CNT_W'(1)) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
            wrap    = 1'b1;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          if (cnt >= period_act) begin
            if (period_act == CNT_W'(1)) begin
              cnt_nxt = '0;
              wrap    = 1'b1;
            end else begin
              cnt_nxt = period_act - CNT_W'(1);
              dir_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < CHANNELS; i++)
      raw[i] = cnt < duty_act[i*CNT_W +: CNT_W];
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pre_cnt      <= '0;
      cnt          <= '0;
      dir_down     <= 1'b0;
      duty_act     <= '0;
      shadow       <= '0;
      busy         <= 1'b0;
      period_act   <= CNT_W'(PERIOD_RST);
      prescale_act <= '0;
      mode_act     <= 1'b0;
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      if (!enable) begin
        pre_cnt  <= '0;
        cnt      <= '0;
        dir_down <= 1'b0;
      end else if (tick) begin
        pre_cnt  <= '0;
        cnt      <= cnt_nxt;
        dir_down <= dir_nxt;
      end else begin
        pre_cnt  <= pre_cnt + PRE_W'(1);
      end
      period_start <= wrap;
      if (commit) begin
        period_act   <= period;
        prescale_act <= prescale;
        mode_act     <= center_mode;
        if (busy)
          duty_act <= shadow;
      end
      // a write racing a commit stays pending for the next one
      if (duty_wr) begin
        shadow <= duty_in;
        busy   <= 1'b1;
      end else if (commit) begin
        busy   <= 1'b0;
      end
      pwm_out <= raw ^ invert;
    end
  end

  assign duty_busy = busy;
  assign cnt_out   = cnt;

endmodule
